// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: core/loader request buses and SRAM port of the data-memory arbiter
// Ports (arbiter view): i_c_*/i_l_* request side, o_c_*/o_l_* grant/response,
// o_rdata shared read data, o_d_mem_* SRAM drive, i_d_mem_di SRAM read data,
// o_stall_cnt core stall counter.
interface dmem_arbiter_if #(parameter int AWIDTH = 12, parameter int DWIDTH = 32);
    logic              i_c_req, i_c_lock, i_c_wen;
    logic [3:0]        i_c_be;
    logic [AWIDTH-1:0] i_c_addr;
    logic [DWIDTH-1:0] i_c_wdata;
    logic              o_c_gnt, o_c_rvalid;
    logic              i_l_req, i_l_lock, i_l_wen;
    logic [3:0]        i_l_be;
    logic [AWIDTH-1:0] i_l_addr;
    logic [DWIDTH-1:0] i_l_wdata;
    logic              o_l_gnt, o_l_rvalid;
    logic [DWIDTH-1:0] o_rdata;
    logic              o_d_mem_csn, o_d_mem_wen;
    logic [3:0]        o_d_mem_be;
    logic [AWIDTH-1:0] o_d_mem_addr;
    logic [DWIDTH-1:0] o_d_mem_dout;
    logic [DWIDTH-1:0] i_d_mem_di;
    logic [31:0]       o_stall_cnt;
    modport slave (
        input  i_c_req, i_c_lock, i_c_wen, i_c_be, i_c_addr, i_c_wdata,
        input  i_l_req, i_l_lock, i_l_wen, i_l_be, i_l_addr, i_l_wdata, i_d_mem_di,
        output o_c_gnt, o_c_rvalid, o_l_gnt, o_l_rvalid, o_rdata,
        output o_d_mem_csn, o_d_mem_wen, o_d_mem_be, o_d_mem_addr, o_d_mem_dout, o_stall_cnt
    );
    modport master (
        output i_c_req, i_c_lock, i_c_wen, i_c_be, i_c_addr, i_c_wdata,
        output i_l_req, i_l_lock, i_l_wen, i_l_be, i_l_addr, i_l_wdata, i_d_mem_di,
        input  o_c_gnt, o_c_rvalid, o_l_gnt, o_l_rvalid, o_rdata,
        input  o_d_mem_csn, o_d_mem_wen, o_d_mem_be, o_d_mem_addr, o_d_mem_dout, o_stall_cnt
    );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin arbiter with bounded burst lock sharing one data SRAM
// Ports: i_clk clock, i_rstn async active-low reset, bus (dmem_arbiter_if.slave)
// carrying core/loader requests, grants, read-valid pulses, SRAM drive and stall count.
module dmem_arbiter #(parameter int MAX_BURST = 8) (
    input logic          i_clk,
    input logic          i_rstn,
    dmem_arbiter_if.slave bus
);
    localparam int BW = $clog2(MAX_BURST + 1);
    localparam logic [BW-1:0] MAX_B = BW'(MAX_BURST);
    typedef enum logic [1:0] {OWN_NONE, OWN_CORE, OWN_LOAD} owner_t;
    owner_t        r_owner, r_last, w_owner_nx, w_last_nx;
    logic [BW-1:0] r_burst, w_burst_nx;
    logic          r_rv_c, r_rv_l;
    logic [31:0]   r_stall_cnt;
    logic          w_hold_c, w_hold_l, w_gnt_c, w_gnt_l, w_any, w_lock;
    // The current owner keeps the memory on a tie only while its lock run is below the limit
    assign w_hold_c = r_owner == OWN_CORE && bus.i_c_lock && r_burst < MAX_B;
    assign w_hold_l = r_owner == OWN_LOAD && bus.i_l_lock && r_burst < MAX_B;
    assign w_gnt_c  = i_rstn && bus.i_c_req && (!bus.i_l_req || w_hold_c || (!w_hold_l && r_last != OWN_CORE));
    assign w_gnt_l  = i_rstn && bus.i_l_req && !w_gnt_c;
    assign w_any    = w_gnt_c || w_gnt_l;
    assign w_lock   = w_gnt_c ? bus.i_c_lock : bus.i_l_lock;
    assign bus.o_c_gnt      = w_gnt_c;
    assign bus.o_l_gnt      = w_gnt_l;
    assign bus.o_c_rvalid   = r_rv_c;
    assign bus.o_l_rvalid   = r_rv_l;
    assign bus.o_rdata      = bus.i_d_mem_di;
    assign bus.o_stall_cnt  = r_stall_cnt;
    assign bus.o_d_mem_csn  = !w_any;
    assign bus.o_d_mem_wen  = w_gnt_c ? bus.i_c_wen   : w_gnt_l ? bus.i_l_wen   : 1'b1;
    assign bus.o_d_mem_be   = w_gnt_c ? bus.i_c_be    : w_gnt_l ? bus.i_l_be    : '0;
    assign bus.o_d_mem_addr = w_gnt_c ? bus.i_c_addr  : w_gnt_l ? bus.i_l_addr  : '0;
    assign bus.o_d_mem_dout = w_gnt_c ? bus.i_c_wdata : w_gnt_l ? bus.i_l_wdata : '0;
    always_comb begin
        w_owner_nx = OWN_NONE;
        w_last_nx  = r_last;
        w_burst_nx = '0;
        if (w_any) begin
            w_owner_nx = w_gnt_c ? OWN_CORE : OWN_LOAD;
            w_last_nx  = w_owner_nx;
            // An unlocked grant clears the run so the next locked access starts fresh
            w_burst_nx = !w_lock ? '0 : w_owner_nx != r_owner ? BW'(1) : r_burst == MAX_B ? MAX_B : r_burst + 1'b1;
        end
    end
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_owner     <= OWN_NONE;
            r_last      <= OWN_LOAD;
            r_burst     <= '0;
            r_rv_c      <= 1'b0;
            r_rv_l      <= 1'b0;
            r_stall_cnt <= '0;
        end else begin
            r_owner <= w_owner_nx;
            r_last  <= w_last_nx;
            r_burst <= w_burst_nx;
            r_rv_c  <= w_gnt_c && bus.i_c_wen;
            r_rv_l  <= w_gnt_l && bus.i_l_wen;
            if (bus.i_c_req && !w_gnt_c && r_stall_cnt != '1)
                r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed scoreboard bench for dmem_arbiter with an SRAM model
module tb_dmem_arbiter;
    logic        clk = 1'b0;
    logic        rstn;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] mem     [0:4095];
    logic [31:0] ref_mem [0:4095];
    logic [31:0] exp_c[$];
    logic [31:0] exp_l[$];
    logic        c_done;

    dmem_arbiter_if #(.AWIDTH(12), .DWIDTH(32)) bus ();
    dmem_arbiter #(.MAX_BURST(8)) dut (.i_clk(clk), .i_rstn(rstn), .bus(bus.slave));

    always #5 clk = ~clk;

    // Single-port SRAM: byte-masked writes, read data registered one cycle
    always @(posedge clk) begin
        if (!bus.o_d_mem_csn) begin
            if (bus.o_d_mem_wen)
                bus.i_d_mem_di <= mem[bus.o_d_mem_addr];
            else
                for (int i = 0; i < 4; i++)
                    if (bus.o_d_mem_be[i]) mem[bus.o_d_mem_addr][8*i +: 8] <= bus.o_d_mem_dout[8*i +: 8];
        end
    end

    task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Response side of the scoreboard
    always @(negedge clk) begin
        if (bus.o_c_rvalid) begin
            if (exp_c.size() == 0) chk(1'b1, 1'b0, "c_rvalid_unexpected");
            else chk(bus.o_rdata, exp_c.pop_front(), "c_rdata");
        end
        if (bus.o_l_rvalid) begin
            if (exp_l.size() == 0) chk(1'b1, 1'b0, "l_rvalid_unexpected");
            else chk(bus.o_rdata, exp_l.pop_front(), "l_rdata");
        end
    end

    task automatic ref_write(input logic [11:0] a, input logic [3:0] be, input logic [31:0] d);
        for (int i = 0; i < 4; i++)
            if (be[i]) ref_mem[a][8*i +: 8] = d[8*i +: 8];
    endtask

    task automatic drive_c(input logic req, lock, wen, input logic [3:0] be, input logic [11:0] addr, input logic [31:0] data);
        bus.i_c_req = req; bus.i_c_lock = lock; bus.i_c_wen = wen;
        bus.i_c_be = be; bus.i_c_addr = addr; bus.i_c_wdata = data;
    endtask

    task automatic drive_l(input logic req, lock, wen, input logic [3:0] be, input logic [11:0] addr, input logic [31:0] data);
        bus.i_l_req = req; bus.i_l_lock = lock; bus.i_l_wen = wen;
        bus.i_l_be = be; bus.i_l_addr = addr; bus.i_l_wdata = data;
    endtask

    // One cycle: check grants, record expected effects of granted accesses, advance
    task automatic step(input logic eg_c, input logic eg_l, input string tag);
        #1;
        chk(bus.o_c_gnt, eg_c, {tag, ".c_gnt"});
        chk(bus.o_l_gnt, eg_l, {tag, ".l_gnt"});
        if (eg_c) begin
            if (bus.i_c_wen) exp_c.push_back(ref_mem[bus.i_c_addr]);
            else ref_write(bus.i_c_addr, bus.i_c_be, bus.i_c_wdata);
        end
        if (eg_l) begin
            if (bus.i_l_wen) exp_l.push_back(ref_mem[bus.i_l_addr]);
            else ref_write(bus.i_l_addr, bus.i_l_be, bus.i_l_wdata);
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        drive_c(0, 0, 1, 4'h0, 12'h0, 32'h0);
        drive_l(0, 0, 1, 4'h0, 12'h0, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rstn = 1'b0;
        drive_c(1, 0, 1, 4'hF, 12'h0, 32'h0);
        drive_l(1, 0, 1, 4'hF, 12'h0, 32'h0);
        @(negedge clk);
        #1;
        chk(bus.o_c_gnt, 1'b0, "rst.c_gnt");
        chk(bus.o_l_gnt, 1'b0, "rst.l_gnt");
        chk(bus.o_d_mem_csn, 1'b1, "rst.csn");
        chk(bus.o_stall_cnt, 32'h0, "rst.stall");
        chk(bus.o_c_rvalid, 1'b0, "rst.c_rvalid");
        @(negedge clk);
        rstn = 1'b1;
        drive_c(0, 0, 1, 4'h0, 12'h0, 32'h0);
        drive_l(1, 0, 0, 4'hF, 12'h010, 32'hDEADBEEF);
        step(0, 1, "preload");
        drive_l(0, 0, 1, 4'h0, 12'h0, 32'h0);
        #1;
        chk(bus.o_d_mem_csn, 1'b1, "idle.csn");
        chk(bus.o_d_mem_wen, 1'b1, "idle.wen");
        chk(bus.o_d_mem_be, 4'h0, "idle.be");
        chk(bus.o_d_mem_addr, 12'h0, "idle.addr");
        chk(bus.o_d_mem_dout, 32'h0, "idle.dout");
        @(negedge clk);

        do_reset();
        drive_c(1, 0, 1, 4'hF, 12'h010, 32'h0);
        step(1, 0, "c_read");
        drive_c(0, 0, 1, 4'h0, 12'h0, 32'h0);
        step(0, 0, "c_read_resp");
        chk(bus.o_stall_cnt, 32'h0, "c_read.stall");

        drive_l(1, 0, 0, 4'hF, 12'h3FC, 32'h12345678);
        step(0, 1, "l_wr");
        drive_l(0, 0, 1, 4'h0, 12'h0, 32'h0);
        drive_c(1, 0, 1, 4'hF, 12'h3FC, 32'h0);
        step(1, 0, "c_rd_3fc");
        drive_c(0, 0, 1, 4'h0, 12'h0, 32'h0);
        drive_l(1, 0, 0, 4'h3, 12'h3FC, 32'hAAAAAAAA);
        step(0, 1, "l_wr_be3");
        drive_l(0, 0, 1, 4'h0, 12'h0, 32'h0);
        drive_c(1, 0, 1, 4'hF, 12'h3FC, 32'h0);
        step(1, 0, "c_rd_be3");
        drive_c(0, 0, 1, 4'h0, 12'h0, 32'h0);
        step(0, 0, "c_rd_drain");

        do_reset();
        drive_c(1, 0, 1, 4'hF, 12'h010, 32'h0);
        drive_l(1, 0, 1, 4'hF, 12'h3FC, 32'h0);
        for (int i = 0; i < 6; i++) step(i % 2 == 0, i % 2 == 1, $sformatf("tie%0d", i));
        chk(bus.o_stall_cnt, 32'd3, "tie.stall");
        drive_c(0, 0, 1, 4'h0, 12'h0, 32'h0);
        drive_l(0, 0, 1, 4'h0, 12'h0, 32'h0);
        step(0, 0, "tie_drain");

        do_reset();
        c_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            drive_l(1, 1, 0, 4'hF, 12'(256 + i), 32'(i) * 32'h11111111);
            drive_c(i >= 2 && !c_done, 0, 1, 4'hF, 12'h3FC, 32'h0);
            step(i == 8, i != 8, $sformatf("lock%0d", i));
            c_done = c_done || i == 8;
        end
        chk(bus.o_stall_cnt, 32'd6, "lock.stall");
        drive_l(0, 0, 1, 4'h0, 12'h0, 32'h0);
        drive_c(1, 0, 1, 4'hF, 12'h107, 32'h0);
        step(1, 0, "lock_rdback");
        drive_c(0, 0, 1, 4'h0, 12'h0, 32'h0);
        step(0, 0, "lock_drain");

        drive_c(1, 0, 1, 4'hF, 12'h107, 32'h0);
        #1;
        chk(bus.o_c_gnt, 1'b1, "midrst.c_gnt");
        @(posedge clk);
        #2;
        rstn = 1'b0;
        #1;
        chk(bus.o_c_rvalid, 1'b0, "midrst.c_rvalid");
        chk(bus.o_c_gnt, 1'b0, "midrst.gnt");
        chk(bus.o_d_mem_csn, 1'b1, "midrst.csn");
        chk(bus.o_stall_cnt, 32'h0, "midrst.stall");
        @(negedge clk);
        rstn = 1'b1;
        drive_l(1, 0, 1, 4'hF, 12'h010, 32'h0);
        step(1, 0, "midrst_tie");
        drive_c(0, 0, 1, 4'h0, 12'h0, 32'h0);
        step(0, 1, "midrst_l");
        drive_l(0, 0, 1, 4'h0, 12'h0, 32'h0);
        step(0, 0, "midrst_drain");

        do_reset();
        drive_l(1, 1, 0, 4'hF, 12'h200, 32'h55);
        @(negedge clk);
        drive_c(1, 0, 0, 4'hF, 12'h201, 32'h66);
        @(negedge clk);
        force dut.r_stall_cnt = 32'hFFFF_FFFE;
        @(posedge clk);
        #1;
        release dut.r_stall_cnt;
        repeat (3) @(negedge clk);
        chk(bus.o_stall_cnt, 32'hFFFF_FFFF, "sat.stall");
        drive_c(0, 0, 1, 4'h0, 12'h0, 32'h0);
        drive_l(0, 0, 1, 4'h0, 12'h0, 32'h0);
        @(negedge clk);

        chk(32'(exp_c.size()), 32'd0, "c_pending");
        chk(32'(exp_l.size()), 32'd0, "l_pending");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
